// File: rtl/apb_cmd_pkg.sv
// Shared types and default widths for the APB4 command requester.
// TIMEOUT_W follows the default ACCESS-phase cycle limit.
package apb_cmd_pkg;

    localparam int unsigned CMD_ADDR_W          = 12;
    localparam int unsigned CMD_DATA_W          = 32;
    localparam int unsigned CMD_STRB_W          = CMD_DATA_W / 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF  = 256;
    localparam int unsigned TIMEOUT_W           = $clog2(TIMEOUT_CYCLES_DEF);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic [CMD_STRB_W-1:0] strb;
    } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_master.sv
// APB4 requester: one valid/ready command in, one SETUP/ACCESS transfer, one response out.
// Optional ACCESS-phase timeout enabled by defining APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned DATA_W         = 32,
    parameter logic [2:0]  PPROT_VAL      = 3'b000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   paddr,
    output logic                pwrite,
    output logic                psel,
    output logic                penable,
    output logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   pwdata,
    output logic [2:0]          pprot,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;

    apb_state_e          state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pstrb_d     = pstrb_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_wdata;
                    pstrb_d   = cmd_write ? cmd_strb : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                // Completer never answered: abandon the transfer and report an error.
                else if (cnt_q == CNT_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pstrb_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pstrb_q     <= pstrb_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Gated by rst_n so no command is taken while reset is held.
    assign cmd_ready = rst_n && (state_q == IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pstrb     = pstrb_q;
    assign pwdata    = pwdata_q;
    assign pprot     = PPROT_VAL;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
